// File: rtl/cpu_pkg.sv
// Shared core definitions: default widths, halt encoding, fetch FSM states and the
// branch-kind bundle handed from control to fetch/execute.
package cpu_pkg;

    localparam int unsigned DefaultXlen    = 64;
    localparam logic [63:0] DefaultInitPc  = 64'h0;
    localparam logic [31:0] DefaultHltInsn = 32'hD440_0000;

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StHold,
        StHalted
    } fetch_state_e;

    typedef struct packed {
        logic uncond;  // B / BL
        logic zero;    // CBZ / CBNZ
        logic flag;    // B.cond
    } br_kind_t;

endpackage

// File: rtl/branch_target.sv
// Combinational branch resolution: taken decision, target adder and word-alignment check.
module branch_target import cpu_pkg::*; #(
    parameter int unsigned XLEN = DefaultXlen
) (
    input  logic            br_valid,
    input  br_kind_t        br_kind,
    input  logic            alu_zero,
    input  logic            cond_true,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_offset,
    output logic            taken,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    always_comb begin
        taken = br_valid & (br_kind.uncond
                            | (br_kind.zero & alu_zero)
                            | (br_kind.flag & cond_true));
        // Word offset scaled to bytes; the sum wraps modulo 2^XLEN.
        target     = br_pc + {br_offset[XLEN-3:0], 2'b00};
        misaligned = |target[1:0];
    end

endmodule

// File: rtl/fetch_unit.sv
// PC/fetch stage: one outstanding imem request, valid/ready delivery, branch redirect and HLT.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit import cpu_pkg::*; #(
    parameter int unsigned     XLEN     = DefaultXlen,
    parameter logic [XLEN-1:0] INIT_PC  = DefaultInitPc[XLEN-1:0],
    parameter logic [31:0]     HLT_INSN = DefaultHltInsn
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            br_valid,
    input  logic            br_uncond,
    input  logic            br_zero,
    input  logic            br_flag,
    input  logic            alu_zero,
    input  logic            cond_true,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_offset,
    output logic [XLEN-1:0] pc,
    output logic            halted,
    output logic            fault,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_squashed
);

    localparam logic [XLEN-1:0] PcStep = XLEN'(4);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic [31:0]     inst_q, inst_d;
    logic            squash_q, squash_d;
    logic            pending_q, pending_d;
    logic            fault_q, fault_d;

    br_kind_t        br_kind;
    logic            br_taken;
    logic            br_misaligned;
    logic [XLEN-1:0] br_target;
    logic            redirect;
    logic            fetched_inc;
    logic            squashed_inc;

    assign br_kind.uncond = br_uncond;
    assign br_kind.zero   = br_zero;
    assign br_kind.flag   = br_flag;

    branch_target #(
        .XLEN(XLEN)
    ) u_branch_target (
        .br_valid  (br_valid),
        .br_kind   (br_kind),
        .alu_zero  (alu_zero),
        .cond_true (cond_true),
        .br_pc     (br_pc),
        .br_offset (br_offset),
        .taken     (br_taken),
        .target    (br_target),
        .misaligned(br_misaligned)
    );

    assign redirect = br_taken && (state_q != StHalted);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        squash_d     = squash_q;
        pending_d    = pending_q;
        fault_d      = fault_q;
        fetched_inc  = 1'b0;
        squashed_inc = 1'b0;

        unique case (state_q)
            StReq: begin
                if (imem_req_ready) begin
                    pending_d = 1'b1;
                    state_d   = StWait;
                end
                if (redirect) begin
                    pc_d = br_target;
                    // Request already in flight for the old PC: its response must be dropped.
                    if (imem_req_ready) begin
                        squash_d = 1'b1;
                    end
                end
            end
            StWait: begin
                if (redirect) begin
                    pc_d = br_target;
                end
                // pending_q guards against a response belonging to a pre-reset request.
                if (imem_rsp_valid && pending_q) begin
                    pending_d = 1'b0;
                    if (squash_q || redirect) begin
                        squash_d     = 1'b0;
                        squashed_inc = 1'b1;
                        state_d      = StReq;
                    end else begin
                        inst_d    = imem_rsp_data;
                        inst_pc_d = pc_q;
                        state_d   = StHold;
                    end
                end else if (redirect) begin
                    squash_d = 1'b1;
                end
            end
            StHold: begin
                if (redirect) begin
                    pc_d         = br_target;
                    squashed_inc = 1'b1;
                    state_d      = StReq;
                end else if (inst_ready) begin
                    fetched_inc = 1'b1;
                    if (inst_q == HLT_INSN) begin
                        state_d = StHalted;
                    end else begin
                        pc_d    = pc_q + PcStep;
                        state_d = StReq;
                    end
                end
            end
            StHalted: begin
            end
            default: begin
                state_d = StReq;
            end
        endcase

        // A misaligned target never reaches the request port.
        if (redirect && br_misaligned) begin
            pc_d     = pc_q;
            squash_d = 1'b0;
            fault_d  = 1'b1;
            state_d  = StHalted;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StReq;
            pc_q      <= INIT_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
            squash_q  <= 1'b0;
            pending_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            squash_q  <= squash_d;
            pending_q <= pending_d;
            fault_q   <= fault_d;
        end
    end

    // Gated by reset so no request is presented while reset is held.
    assign imem_req_valid = (state_q == StReq) && !reset;
    assign imem_addr      = pc_q;
    assign inst_valid     = (state_q == StHold);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign pc             = pc_q;
    assign halted         = (state_q == StHalted);
    assign fault          = fault_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q;
    logic [31:0] squashed_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q  <= '0;
            squashed_q <= '0;
        end else if (state_q != StHalted) begin
            if (fetched_inc) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if (squashed_inc) begin
                squashed_q <= squashed_q + 32'd1;
            end
        end
    end

    assign perf_fetched  = fetched_q;
    assign perf_squashed = squashed_q;
`else
    logic unused_perf;
    assign unused_perf   = fetched_inc ^ squashed_inc;
    assign perf_fetched  = '0;
    assign perf_squashed = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a variable-latency instruction memory model.
module tb_fetch_unit;

    localparam int unsigned XLEN    = 64;
    localparam logic [63:0] INIT_PC = 64'h1000;
    localparam logic [31:0] HLT     = 32'hD440_0000;
`ifdef FETCH_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            br_valid, br_uncond, br_zero, br_flag, alu_zero, cond_true;
    logic [XLEN-1:0] br_pc, br_offset;
    logic [XLEN-1:0] pc;
    logic            halted, fault;
    logic [31:0]     perf_fetched, perf_squashed;

    int n_checks = 0;
    int n_errors = 0;

    // Memory model state
    int              mem_lat = 0;
    bit              hlt_en  = 1'b0;
    bit              mem_busy = 1'b0;
    int              mem_cnt = 0;
    logic [63:0]     mem_addr = '0;
    logic [63:0]     req_log[$];
    logic [63:0]     hs_pc[$];
    logic [31:0]     hs_inst[$];

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN    (XLEN),
        .INIT_PC (INIT_PC),
        .HLT_INSN(HLT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .br_valid      (br_valid),
        .br_uncond     (br_uncond),
        .br_zero       (br_zero),
        .br_flag       (br_flag),
        .alu_zero      (alu_zero),
        .cond_true     (cond_true),
        .br_pc         (br_pc),
        .br_offset     (br_offset),
        .pc            (pc),
        .halted        (halted),
        .fault         (fault),
        .perf_fetched  (perf_fetched),
        .perf_squashed (perf_squashed)
    );

    function automatic logic [31:0] word(input logic [63:0] a);
        if (hlt_en && a == 64'h100C) return HLT;
        return {16'h8B00, a[15:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_br();
        br_valid  = 1'b0;
        br_uncond = 1'b0;
        br_zero   = 1'b0;
        br_flag   = 1'b0;
        alu_zero  = 1'b0;
        cond_true = 1'b0;
        br_pc     = '0;
        br_offset = '0;
    endtask

    task automatic do_reset(input int lat, input bit hlt, input logic rdy);
        reset = 1'b1;
        cyc(6);
        mem_lat    = lat;
        hlt_en     = hlt;
        inst_ready = rdy;
        req_log.delete();
        hs_pc.delete();
        hs_inst.delete();
        reset = 1'b0;
    endtask

    // Memory and handshake monitor act just after the falling edge, after stimulus settles.
    initial begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (mem_busy) begin
                if (mem_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = word(mem_addr);
                    mem_busy       = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end
            imem_req_ready = !mem_busy;
            if (imem_req_valid && imem_req_ready) begin
                mem_busy = 1'b1;
                mem_cnt  = mem_lat;
                mem_addr = imem_addr;
                req_log.push_back(imem_addr);
            end
            if (inst_valid && inst_ready) begin
                hs_pc.push_back(inst_pc);
                hs_inst.push_back(inst);
            end
        end
    end

    initial begin
        int  req_cycles;
        bit  bad;
        logic [31:0] held;

        reset      = 1'b1;
        inst_ready = 1'b1;
        clear_br();
        cyc(3);

        // Reset state
        check_eq("rst_pc", pc, INIT_PC);
        check_eq("rst_req_valid", imem_req_valid, 0);
        check_eq("rst_inst_valid", inst_valid, 0);
        check_eq("rst_inst", inst, 0);
        check_eq("rst_inst_pc", inst_pc, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_fault", fault, 0);
        check_eq("rst_perf_fetched", perf_fetched, 0);
        check_eq("rst_perf_squashed", perf_squashed, 0);

        // Sequential fetch, zero-latency memory
        do_reset(0, 1'b0, 1'b1);
        for (int i = 0; i < 60 && hs_pc.size() < 3; i++) cyc(1);
        check_eq("seq_hs_count_ge3", hs_pc.size() >= 3, 1);
        if (hs_pc.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                check_eq($sformatf("seq_addr%0d", i), req_log[i], INIT_PC + 64'(4 * i));
                check_eq($sformatf("seq_inst_pc%0d", i), hs_pc[i], INIT_PC + 64'(4 * i));
                check_eq($sformatf("seq_inst%0d", i), hs_inst[i], word(INIT_PC + 64'(4 * i)));
            end
        end
        check_eq("seq_halted", halted, 0);

        // Latency 3, downstream stalls for 4 cycles
        do_reset(3, 1'b0, 1'b0);
        for (int i = 0; i < 40 && !inst_valid; i++) cyc(1);
        check_eq("stall_inst_valid", inst_valid, 1);
        held = inst;
        cyc(4);
        check_eq("stall_inst_stable", inst, held);
        check_eq("stall_inst_word", inst, word(INIT_PC));
        check_eq("stall_single_req", req_log.size(), 1);
        check_eq("stall_no_req", imem_req_valid, 0);
        inst_ready = 1'b1;
        cyc(1);
        inst_ready = 1'b0;
        check_eq("stall_next_req_valid", imem_req_valid, 1);
        check_eq("stall_next_addr", imem_addr, INIT_PC + 64'h4);
        check_eq("stall_inst_valid_drop", inst_valid, 0);

        // Unconditional B during WAIT: response dropped, refetch at 0x1000
        do_reset(3, 1'b0, 1'b1);
        for (int i = 0; i < 60 && req_log.size() < 3; i++) cyc(1);
        check_eq("bwait_req3_seen", req_log.size(), 3);
        br_valid  = 1'b1;
        br_uncond = 1'b1;
        br_pc     = 64'h1008;
        br_offset = -64'sd2;
        cyc(1);
        clear_br();
        check_eq("bwait_pc", pc, 64'h1000);
        for (int i = 0; i < 60 && hs_pc.size() < 3; i++) cyc(1);
        check_eq("bwait_hs3_seen", hs_pc.size(), 3);
        if (req_log.size() >= 4) check_eq("bwait_refetch_addr", req_log[3], 64'h1000);
        else check_eq("bwait_req4_seen", req_log.size(), 4);
        if (hs_pc.size() >= 3) check_eq("bwait_hs_pc2", hs_pc[2], 64'h1000);
        check_eq("bwait_perf_squashed", perf_squashed, PerfEn ? 1 : 0);

        // CBZ not taken, then B.cond taken while holding an instruction
        do_reset(0, 1'b0, 1'b0);
        for (int i = 0; i < 40 && !inst_valid; i++) cyc(1);
        check_eq("cbz_hold", inst_valid, 1);
        br_valid  = 1'b1;
        br_zero   = 1'b1;
        alu_zero  = 1'b0;
        br_pc     = 64'h3000;
        br_offset = 64'd8;
        cyc(1);
        clear_br();
        check_eq("cbz_nt_inst_valid", inst_valid, 1);
        check_eq("cbz_nt_pc", pc, INIT_PC);
        br_valid  = 1'b1;
        br_flag   = 1'b1;
        cond_true = 1'b1;
        br_pc     = 64'h2000;
        br_offset = 64'd4;
        cyc(1);
        clear_br();
        check_eq("bcond_drop", inst_valid, 0);
        check_eq("bcond_pc", pc, 64'h2010);
        check_eq("bcond_req_valid", imem_req_valid, 1);
        check_eq("bcond_addr", imem_addr, 64'h2010);

        // HLT at 0x100C
        do_reset(0, 1'b1, 1'b1);
        for (int i = 0; i < 80 && hs_pc.size() < 4; i++) cyc(1);
        check_eq("hlt_hs4_seen", hs_pc.size(), 4);
        check_eq("hlt_halted", halted, 1);
        if (hs_pc.size() >= 4) begin
            check_eq("hlt_inst", hs_inst[3], HLT);
            check_eq("hlt_inst_pc", hs_pc[3], 64'h100C);
        end
        check_eq("hlt_perf_fetched", perf_fetched, PerfEn ? 4 : 0);
        req_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (imem_req_valid) req_cycles++;
        end
        check_eq("hlt_no_req", req_cycles, 0);
        br_valid  = 1'b1;
        br_uncond = 1'b1;
        br_pc     = 64'h0;
        br_offset = 64'd0;
        cyc(1);
        clear_br();
        cyc(1);
        check_eq("hlt_br_ignored_halted", halted, 1);
        check_eq("hlt_br_ignored_pc", pc, 64'h100C);
        check_eq("hlt_br_ignored_req", imem_req_valid, 0);
        check_eq("hlt_fault", fault, 0);

        // Misaligned redirect target during WAIT
        do_reset(3, 1'b0, 1'b1);
        for (int i = 0; i < 40 && req_log.size() < 1; i++) cyc(1);
        br_valid  = 1'b1;
        br_uncond = 1'b1;
        br_pc     = 64'h1002;
        br_offset = 64'd0;
        cyc(1);
        clear_br();
        check_eq("mis_fault", fault, 1);
        check_eq("mis_halted", halted, 1);
        cyc(10);
        bad = 1'b0;
        foreach (req_log[i]) if (req_log[i] == 64'h1002) bad = 1'b1;
        check_eq("mis_no_req_to_target", bad, 0);
        check_eq("mis_req_count", req_log.size(), 1);
        check_eq("mis_req_valid", imem_req_valid, 0);

        // Reset in WAIT: the late response must not be delivered
        do_reset(3, 1'b0, 1'b1);
        for (int i = 0; i < 60 && req_log.size() < 3; i++) cyc(1);
        check_eq("rstw_req3_seen", req_log.size(), 3);
        reset = 1'b1;
        cyc(1);
        check_eq("rstw_pc", pc, INIT_PC);
        check_eq("rstw_inst_valid", inst_valid, 0);
        req_log.delete();
        hs_pc.delete();
        hs_inst.delete();
        reset = 1'b0;
        for (int i = 0; i < 60 && hs_pc.size() < 1; i++) cyc(1);
        check_eq("rstw_hs_seen", hs_pc.size() >= 1, 1);
        if (hs_pc.size() >= 1) begin
            check_eq("rstw_hs_pc", hs_pc[0], INIT_PC);
            check_eq("rstw_hs_inst", hs_inst[0], word(INIT_PC));
            check_eq("rstw_first_addr", req_log[0], INIT_PC);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
